// File: rtl/multi_bank_bram_arbiter.sv
// Address-interleaved multi-bank memory shared by several requester channels.
// Each bank runs its own round-robin arbiter and grants one access per cycle.
// Read data returns a fixed READ_LATENCY (1 or 2) cycles after acceptance.
//
// Handshake: a channel's request is accepted in any cycle where
// req_valid[c] & req_ready[c] is high. req_ready is combinational from the
// same-cycle req_valid/req_addr, is never high without req_valid, and is low
// during rst. A requester holds its request stable until accepted. Responses
// have no backpressure: rsp_valid[c] pulses for one cycle, and rsp_data[c]
// keeps its last value while rsp_valid[c] is low.
module multi_bank_bram_arbiter #(
    parameter int CHANNELS     = 4,
    parameter int BANKS        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            req_valid,
    output logic [CHANNELS-1:0]            req_ready,
    input  logic [CHANNELS-1:0]            req_we,
    input  logic [CHANNELS*STRB_WIDTH-1:0] req_strb,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] req_wdata,
    output logic [CHANNELS-1:0]            rsp_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] rsp_data
);
    localparam int SEL_W = $clog2(BANKS);
    localparam int ROW_W = ADDR_WIDTH - SEL_W;
    localparam int DEPTH = 2 ** ROW_W;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SEL_W-1:0]      ch_bank    [CHANNELS];
    logic [ROW_W-1:0]      ch_row     [CHANNELS];
    logic [CH_W-1:0]       rr_ptr     [BANKS];
    logic                  bank_gnt   [BANKS];
    logic [CH_W-1:0]       bank_ch    [BANKS];
    logic                  bank_we    [BANKS];
    logic                  bank_re    [BANKS];
    logic [ROW_W-1:0]      bank_row   [BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata [BANKS];
    logic [STRB_WIDTH-1:0] bank_strb  [BANKS];
    logic [DATA_WIDTH-1:0] bank_rd    [BANKS];

    logic [CHANNELS-1:0]   s1_valid;
    logic [SEL_W-1:0]      s1_bank    [CHANNELS];
    logic [DATA_WIDTH-1:0] s1_data    [CHANNELS];

    // Split each channel's global word address into bank select and row.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ch_bank[c] = req_addr[c*ADDR_WIDTH +: SEL_W];
            ch_row[c]  = req_addr[c*ADDR_WIDTH+SEL_W +: ROW_W];
        end
    end

    // Per bank: grant the first contender at or after rr_ptr, wrapping around.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_gnt[b] = 1'b0;
            bank_ch[b]  = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                idx = CH_W'((int'(rr_ptr[b]) + i) % CHANNELS);
                if (!rst && !bank_gnt[b] && req_valid[idx] && (ch_bank[idx] == SEL_W'(b))) begin
                    bank_gnt[b] = 1'b1;
                    bank_ch[b]  = idx;
                end
            end
        end
    end

    // Steer the winning channel's request fields onto each bank port.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            bank_we[b]    = bank_gnt[b] && req_we[bank_ch[b]];
            bank_re[b]    = bank_gnt[b] && !req_we[bank_ch[b]];
            bank_row[b]   = ch_row[bank_ch[b]];
            bank_wdata[b] = req_wdata[int'(bank_ch[b])*DATA_WIDTH +: DATA_WIDTH];
            bank_strb[b]  = req_strb[int'(bank_ch[b])*STRB_WIDTH +: STRB_WIDTH];
        end
    end

    // A channel targets exactly one bank, so it is ready iff that bank picked it.
    always_comb begin
        req_ready = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            req_ready[c] = bank_gnt[ch_bank[c]] && (bank_ch[ch_bank[c]] == CH_W'(c));
        end
    end

    // Round-robin pointers move just past the granted channel; hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) rr_ptr[b] <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (bank_gnt[b]) rr_ptr[b] <= CH_W'((int'(bank_ch[b]) + 1) % CHANNELS);
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // Byte-strobed write and registered read; contents survive reset.
        always_ff @(posedge clk) begin
            if (bank_we[b]) begin
                for (int k = 0; k < STRB_WIDTH; k++) begin
                    if (bank_strb[b][k]) mem[bank_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
                end
            end
            if (bank_re[b]) rd_q <= mem[bank_row[b]];
        end

        assign bank_rd[b] = rd_q;
    end

    // Remember which channels launched a read and which bank will hold the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= '0;
            for (int c = 0; c < CHANNELS; c++) s1_bank[c] <= '0;
        end else begin
            s1_valid <= req_valid & req_ready & ~req_we;
            for (int c = 0; c < CHANNELS; c++) s1_bank[c] <= ch_bank[c];
        end
    end

    // Pick up each channel's word from its bank's read register.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) s1_data[c] = bank_rd[s1_bank[c]];
    end

    if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_WIDTH-1:0] hold [CHANNELS];

        // Keep the last delivered word for the cycles between responses.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int c = 0; c < CHANNELS; c++) hold[c] <= '0;
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (s1_valid[c]) hold[c] <= s1_data[c];
                end
            end
        end

        // Forward bank data the cycle after acceptance; a reset cycle drops it.
        always_comb begin
            rsp_valid = s1_valid & {CHANNELS{!rst}};
            rsp_data  = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                rsp_data[c*DATA_WIDTH +: DATA_WIDTH] = rsp_valid[c] ? s1_data[c] : hold[c];
            end
        end
    end else begin : g_lat2
        logic [CHANNELS-1:0]   s2_valid;
        logic [DATA_WIDTH-1:0] s2_data [CHANNELS];

        // Second register stage; data only updates when a response is delivered.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= '0;
                for (int c = 0; c < CHANNELS; c++) s2_data[c] <= '0;
            end else begin
                s2_valid <= s1_valid;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (s1_valid[c]) s2_data[c] <= s1_data[c];
                end
            end
        end

        // Drive the response bus straight from the second stage.
        always_comb begin
            rsp_valid = s2_valid;
            rsp_data  = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                rsp_data[c*DATA_WIDTH +: DATA_WIDTH] = s2_data[c];
            end
        end
    end

endmodule

// File: tb/tb_multi_bank_bram_arbiter.sv
// Directed bench for multi_bank_bram_arbiter: one instance with READ_LATENCY=1
// and a second with READ_LATENCY=2 for the reset-during-read scenario.
module tb_multi_bank_bram_arbiter;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;

    logic clk;
    logic rst;
    logic rst2;

    logic [CH-1:0]    req_valid;
    logic [CH-1:0]    req_ready;
    logic [CH-1:0]    req_we;
    logic [CH*SW-1:0] req_strb;
    logic [CH*AW-1:0] req_addr;
    logic [CH*DW-1:0] req_wdata;
    logic [CH-1:0]    rsp_valid;
    logic [CH*DW-1:0] rsp_data;

    logic [CH-1:0]    v2;
    logic [CH-1:0]    ready2;
    logic [CH-1:0]    we2;
    logic [CH*SW-1:0] strb2;
    logic [CH*AW-1:0] addr2;
    logic [CH*DW-1:0] wd2;
    logic [CH-1:0]    rsp_valid2;
    logic [CH*DW-1:0] rsp_data2;

    int errors;
    int checks;

    multi_bank_bram_arbiter #(
        .CHANNELS(CH), .BANKS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    multi_bank_bram_arbiter #(
        .CHANNELS(CH), .BANKS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)
    ) dut2 (
        .clk(clk), .rst(rst2),
        .req_valid(v2), .req_ready(ready2), .req_we(we2),
        .req_strb(strb2), .req_addr(addr2), .req_wdata(wd2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int c, input logic v, input logic we, input logic [SW-1:0] strb,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid[c]          = v;
        req_we[c]             = we;
        req_strb[c*SW +: SW]  = strb;
        req_addr[c*AW +: AW]  = addr;
        req_wdata[c*DW +: DW] = wd;
    endtask

    task automatic drive2(input int c, input logic v, input logic we, input logic [SW-1:0] strb,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        v2[c]           = v;
        we2[c]          = we;
        strb2[c*SW +: SW] = strb;
        addr2[c*AW +: AW] = addr;
        wd2[c*DW +: DW]   = wd;
    endtask

    function automatic logic [31:0] rdat(input int c);
        return rsp_data[c*DW +: DW];
    endfunction

    function automatic logic [31:0] rdat2(input int c);
        return rsp_data2[c*DW +: DW];
    endfunction

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        rst2      = 1'b1;
        req_valid = '0; req_we = '0; req_strb = '0; req_addr = '0; req_wdata = '0;
        v2        = '0; we2 = '0; strb2 = '0; addr2 = '0; wd2 = '0;

        // Reset: a request presented during rst must not be accepted.
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0005, 32'h1234_5678);
        tick();
        tick();
        chk("rst_ready", {28'd0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
        chk("rst_rsp_data0", rdat(0), 32'h0);
        chk("rst_rsp_data3", rdat(3), 32'h0);
        req_valid = '0;
        rst = 1'b0;

        // Test 1: full write then read back at latency 1.
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0005, 32'hDEAD_BEEF);
        settle();
        chk("t1_wr_ready", {28'd0, req_ready}, 32'h1);
        tick();
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0005, 32'h0);
        settle();
        chk("t1_rd_ready", {28'd0, req_ready}, 32'h1);
        chk("t1_wr_no_rsp", {28'd0, rsp_valid}, 32'h0);
        tick();
        req_valid = '0;
        chk("t1_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        chk("t1_rsp_data", rdat(0), 32'hDEAD_BEEF);
        tick();
        chk("t1_rsp_pulse", {28'd0, rsp_valid}, 32'h0);
        chk("t1_rsp_hold", rdat(0), 32'hDEAD_BEEF);

        // Test 2: partial byte write keeps unstrobed bytes.
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0010, 32'h1122_3344);
        tick();
        drive(0, 1'b1, 1'b1, 4'b0010, 16'h0010, 32'h0000_AA00);
        tick();
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0010, 32'h0);
        tick();
        req_valid = '0;
        chk("t2_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        chk("t2_partial", rdat(0), 32'h1122_AA44);

        // Test 3: four channels on distinct banks are all granted together.
        for (int c = 0; c < CH; c++) drive(c, 1'b1, 1'b1, 4'hF, AW'(c), 32'h1000_0000 + 32'(c));
        settle();
        chk("t3_wr_ready_all", {28'd0, req_ready}, 32'hF);
        tick();
        for (int c = 0; c < CH; c++) drive(c, 1'b1, 1'b0, 4'h0, AW'(c), 32'h0);
        settle();
        chk("t3_rd_ready_all", {28'd0, req_ready}, 32'hF);
        tick();
        req_valid = '0;
        chk("t3_rsp_valid_all", {28'd0, rsp_valid}, 32'hF);
        chk("t3_data_ch0", rdat(0), 32'h1000_0000);
        chk("t3_data_ch1", rdat(1), 32'h1000_0001);
        chk("t3_data_ch2", rdat(2), 32'h1000_0002);
        chk("t3_data_ch3", rdat(3), 32'h1000_0003);

        // Test 4: preload bank 0 rows, reset, then four channels contend on bank 0.
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0004, 32'h2000_0004);
        tick();
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0008, 32'h2000_0008);
        tick();
        drive(0, 1'b1, 1'b1, 4'hF, 16'h000C, 32'h2000_000C);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        drive(1, 1'b1, 1'b0, 4'h0, 16'h0004, 32'h0);
        drive(2, 1'b1, 1'b0, 4'h0, 16'h0008, 32'h0);
        drive(3, 1'b1, 1'b0, 4'h0, 16'h000C, 32'h0);
        settle();
        chk("t4_grant_ch0", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid[0] = 1'b0;
        chk("t4_rsp_ch0", {28'd0, rsp_valid}, 32'h1);
        chk("t4_data_ch0", rdat(0), 32'h1000_0000);
        settle();
        chk("t4_grant_ch1", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid[1] = 1'b0;
        chk("t4_rsp_ch1", {28'd0, rsp_valid}, 32'h2);
        chk("t4_data_ch1", rdat(1), 32'h2000_0004);
        settle();
        chk("t4_grant_ch2", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid[2] = 1'b0;
        chk("t4_rsp_ch2", {28'd0, rsp_valid}, 32'h4);
        chk("t4_data_ch2", rdat(2), 32'h2000_0008);
        settle();
        chk("t4_grant_ch3", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid[3] = 1'b0;
        chk("t4_rsp_ch3", {28'd0, rsp_valid}, 32'h8);
        chk("t4_data_ch3", rdat(3), 32'h2000_000C);

        // Bank 0 pointer is back to 0; one grant to ch0 moves it to 1.
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        tick();
        req_valid = '0;
        // With rr_ptr=1, ch2 wins over ch0, then ch0 follows.
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        drive(2, 1'b1, 1'b0, 4'h0, 16'h0008, 32'h0);
        settle();
        chk("t4b_grant_ch2_first", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid[2] = 1'b0;
        chk("t4b_data_ch2", rdat(2), 32'h2000_0008);
        settle();
        chk("t4b_grant_ch0_next", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        chk("t4b_rsp_ch0", {28'd0, rsp_valid}, 32'h1);
        chk("t4b_data_ch0", rdat(0), 32'h1000_0000);

        // Test 6: read-after-write from another channel on the next cycle.
        drive(1, 1'b1, 1'b1, 4'hF, 16'h0003, 32'h5A5A_0003);
        settle();
        chk("t6_wr_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        drive(2, 1'b1, 1'b0, 4'h0, 16'h0003, 32'h0);
        settle();
        chk("t6_rd_ready", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = '0;
        chk("t6_rsp_valid", {28'd0, rsp_valid}, 32'h4);
        chk("t6_raw_data", rdat(2), 32'h5A5A_0003);

        // Boundary addresses 0 and 0xFFFF on different banks in one cycle.
        drive(0, 1'b1, 1'b1, 4'hF, 16'h0000, 32'h0C0F_FEE0);
        drive(3, 1'b1, 1'b1, 4'hF, 16'hFFFF, 32'h0BAD_F00D);
        settle();
        chk("bnd_wr_ready", {28'd0, req_ready}, 32'h9);
        tick();
        drive(0, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        drive(3, 1'b1, 1'b0, 4'h0, 16'hFFFF, 32'h0);
        tick();
        req_valid = '0;
        chk("bnd_rsp_valid", {28'd0, rsp_valid}, 32'h9);
        chk("bnd_data_addr0", rdat(0), 32'h0C0F_FEE0);
        chk("bnd_data_addr_max", rdat(3), 32'h0BAD_F00D);

        // Test 5: READ_LATENCY=2 instance, normal read then reset during a read.
        rst2 = 1'b0;
        drive2(0, 1'b1, 1'b1, 4'hF, 16'h0020, 32'hCAFE_F00D);
        settle();
        chk("t5_wr_ready", {28'd0, ready2}, 32'h1);
        tick();
        drive2(0, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0);
        tick();
        v2 = '0;
        chk("t5_lat2_not_yet", {28'd0, rsp_valid2}, 32'h0);
        tick();
        chk("t5_lat2_valid", {28'd0, rsp_valid2}, 32'h1);
        chk("t5_lat2_data", rdat2(0), 32'hCAFE_F00D);
        tick();
        chk("t5_lat2_pulse", {28'd0, rsp_valid2}, 32'h0);
        chk("t5_lat2_hold", rdat2(0), 32'hCAFE_F00D);
        drive2(0, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0);
        settle();
        chk("t5_rd2_ready", {28'd0, ready2}, 32'h1);
        tick();
        v2 = '0;
        rst2 = 1'b1;
        tick();
        chk("t5_rst_no_rsp", {28'd0, rsp_valid2}, 32'h0);
        chk("t5_rst_data_zero", rdat2(0), 32'h0);
        rst2 = 1'b0;
        tick();
        chk("t5_after_rst_no_rsp", {28'd0, rsp_valid2}, 32'h0);
        // rr_ptr for bank 0 was 1 before reset; after reset ch0 must win.
        drive2(0, 1'b1, 1'b0, 4'h0, 16'h0020, 32'h0);
        drive2(1, 1'b1, 1'b0, 4'h0, 16'h0024, 32'h0);
        settle();
        chk("t5_rrptr_reset", {28'd0, ready2}, 32'h1);
        tick();
        v2[0] = 1'b0;
        settle();
        chk("t5_rr_next_ch1", {28'd0, ready2}, 32'h2);
        tick();
        v2 = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
